// File: rtl/trace_cache_model.sv
// Direct-mapped cache model driven by an address trace.
// Holds tags and valid bits only (no data). Each accepted address is looked
// up once and produces a single hit/miss response pulse. Running access and
// miss counters saturate at all-ones. A flush walks every set and clears its
// valid bit, one set per cycle.
module trace_cache_model #(
    parameter int ADDR_WIDTH   = 32,
    parameter int OFFSET_BITS  = 4,
    parameter int INDEX_BITS   = 6,
    parameter int MISS_PENALTY = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  addr_valid_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  addr_ready_o,
    input  logic                  flush_i,
    output logic                  resp_valid_o,
    output logic                  resp_hit_o,
    output logic [ADDR_WIDTH-1:0] resp_addr_o,
    output logic [CNT_WIDTH-1:0]  access_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o,
    output logic                  busy_o
);

    localparam int TAG_BITS = ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
    localparam int SETS     = 1 << INDEX_BITS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_FILL   = 3'd2,
        S_RESP   = 3'd3,
        S_FLUSH  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [TAG_BITS-1:0]   tag_array [SETS];
    logic [SETS-1:0]       valid_q;
    logic [7:0]            fill_cnt;
    logic [INDEX_BITS-1:0] flush_idx;
    logic                  hit_q;
    logic [CNT_WIDTH-1:0]  access_cnt;
    logic [CNT_WIDTH-1:0]  miss_cnt;

    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  lookup_hit;
    logic                  accept;

    // Offset bits are dropped entirely; only index and tag take part in a lookup.
    assign index      = addr_q[OFFSET_BITS +: INDEX_BITS];
    assign tag        = addr_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign lookup_hit = valid_q[index] && (tag_array[index] == tag);
    assign accept     = addr_valid_i && addr_ready_o;

    // State register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!rst_i) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state decode; an unknown encoding falls back to IDLE.
    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches.
        state_next = S_IDLE;
        case (state)
            S_IDLE:   if (flush_i)     state_next = S_FLUSH;
                      else if (accept) state_next = S_LOOKUP;
                      else             state_next = S_IDLE;
            S_LOOKUP: state_next = lookup_hit ? S_RESP : S_FILL;
            S_FILL:   state_next = (fill_cnt == 8'd0) ? S_RESP : S_FILL;
            S_RESP:   state_next = S_IDLE;
            S_FLUSH:  state_next = (flush_idx == INDEX_BITS'(SETS - 1)) ? S_IDLE : S_FLUSH;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        addr_ready_o = (state == S_IDLE) && !flush_i;
        busy_o       = (state != S_IDLE);
        resp_valid_o = (state == S_RESP);
    end

    assign resp_hit_o   = hit_q;
    assign resp_addr_o  = addr_q;
    assign access_cnt_o = access_cnt;
    assign miss_cnt_o   = miss_cnt;

    // Datapath: address capture, lookup bookkeeping, fill timer, flush walk.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            addr_q     <= '0;
            valid_q    <= '0;
            fill_cnt   <= '0;
            flush_idx  <= '0;
            hit_q      <= 1'b0;
            access_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush_i)     flush_idx <= '0;
                    else if (accept) addr_q    <= addr_i;
                end
                S_LOOKUP: begin
                    if (access_cnt != '1) access_cnt <= access_cnt + 1'b1;
                    hit_q <= lookup_hit;
                    if (!lookup_hit) begin
                        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
                        valid_q[index] <= 1'b1;
                        fill_cnt       <= 8'(MISS_PENALTY - 1);
                    end
                end
                S_FILL: begin
                    if (fill_cnt != 8'd0) fill_cnt <= fill_cnt - 8'd1;
                end
                S_FLUSH: begin
                    valid_q[flush_idx] <= 1'b0;
                    flush_idx          <= flush_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Tag store: written on every miss.
    always_ff @(posedge clk_i) begin
        // NOTE: tag storage is not reset; the valid bits alone decide whether
        // an entry is meaningful, so the array can map onto plain RAM.
        if (rst_i && state == S_LOOKUP && !lookup_hit) tag_array[index] <= tag;
    end

endmodule
